fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 34 +++
 rtl/fetch_npc.sv | 41 ++++
 rtl/fetch_stage.sv | 72 +++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types, address window defaults and exception codes.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_LO_DEF    = 32'h0000_3000;
  localparam logic [31:0] PC_HI_DEF    = 32'h0000_6FFC;
  localparam logic [31:0] HANDLER_DEF  = 32'h0000_4180;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_BR   = 2'b01,
    NPC_JIMM = 2'b10,
    NPC_JREG = 2'b11
  } npc_sel_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } if_id_t;

  function automatic logic pc_bad(
    input logic [31:0] pc,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

// File: rtl/fetch_npc.sv
// Next-PC selection for fetch: handler, eret, stall, redirect, sequential.
module fetch_npc
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] HANDLER = HANDLER_DEF
) (
  input  logic [31:0] pc,
  input  logic        req,
  input  logic        eret,
  input  logic        en_f,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] npc_d,
  input  logic [31:0] epc,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic        s_req;
  logic        s_eret;
  logic        s_stall;
  logic        s_redir;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    // one-hot selects so the decoder below is truly exclusive
    s_req    = req;
    s_eret   = !req && eret;
    s_stall  = !req && !eret && !en_f;
    s_redir  = !req && !eret && en_f &&
               (npc_sel_e'(npc_sel) != NPC_SEQ);
    npc      = pc_plus4;
    unique case (1'b1)
      s_req:   npc = HANDLER;
      s_eret:  npc = epc;
      s_stall: npc = pc;
      s_redir: npc = npc_d;
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, legal-window check and F-stage output bundle.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] PC_LO    = PC_LO_DEF,
  parameter logic [31:0] PC_HI    = PC_HI_DEF,
  parameter logic [31:0] HANDLER  = HANDLER_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN_F,
  input  logic        Req,
  input  logic        Eret_D,
  input  logic [31:0] EPC,
  input  logic [1:0]  NPCSel_D,
  input  logic [31:0] NPC_D,
  input  logic        IsBranch_D,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] Instr_F2,
  output logic [31:0] PC_F2,
  output logic [4:0]  ExcCode_F2,
  output logic        BD_F2
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        adel;
  if_id_t      f2;

  fetch_npc #(
    .HANDLER (HANDLER)
  ) u_npc (
    .pc      (pc_q),
    .req     (Req),
    .eret    (Eret_D),
    .en_f    (EN_F),
    .npc_sel (NPCSel_D),
    .npc_d   (NPC_D),
    .epc     (EPC),
    .npc     (pc_d)
  );

  always_ff @(posedge clk) begin
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  always_comb begin
    adel     = pc_bad(pc_q, PC_LO, PC_HI);
    f2.pc    = pc_q;
    f2.bd    = IsBranch_D && !Eret_D;
    f2.instr = i_inst_rdata;
    f2.exc   = EXC_NONE;
    // eret kills the wrong-path word and any fault it raised
    if (Eret_D) begin
      f2.instr = '0;
      f2.exc   = EXC_NONE;
    end else if (adel) begin
      f2.instr = '0;
      f2.exc   = EXC_ADEL;
    end
  end

  assign i_inst_addr = pc_q;
  assign PC_F2       = f2.pc;
  assign Instr_F2    = f2.instr;
  assign ExcCode_F2  = f2.exc;
  assign BD_F2       = f2.bd;

endmodule
